// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU vs. load-return writeback, pending-load scoreboard
// and decode hazard. Optional decode bypass outputs enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   ld_issue,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [ADDR_W-1:0]      rs1,
    input  logic [ADDR_W-1:0]      rs2,
    output logic                   hazard,
    output logic                   WE3,
    output logic [ADDR_W-1:0]      A3,
    output logic [DATA_W-1:0]      WD3,
    output logic [(2**ADDR_W)-1:0] sb_busy
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                   byp1_hit,
    output logic                   byp2_hit,
    output logic [DATA_W-1:0]      byp_data
`endif
);

    localparam int unsigned NREG       = 2**ADDR_W;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [0:0] {StNormal, StForceAlu} state_e;

    state_e              r_state;
    logic [3:0]          r_starve_cnt;
    logic                r_we3;
    logic [ADDR_W-1:0]   r_a3;
    logic [DATA_W-1:0]   r_wd3;
    logic [NREG-1:0]     r_sb_busy;

    logic                w_alu_ready;
    logic                w_mem_ready;
    logic                w_alu_xfer;
    logic                w_mem_xfer;
    logic [ADDR_W-1:0]   w_wr_rd;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_en;
    logic [3:0]          w_cnt_inc;
    logic [NREG-1:0]     w_sb_next;
    logic                w_rs1_busy;
    logic                w_rs2_busy;
    logic                w_rs1_fly;
    logic                w_rs2_fly;

    // Mem has priority in normal operation; the starved ALU owns the port in StForceAlu.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (!RST) begin
            if (r_state == StNormal) begin
                w_mem_ready = 1'b1;
                w_alu_ready = !mem_valid;
            end else begin
                w_alu_ready = 1'b1;
                w_mem_ready = !alu_valid;
            end
        end
    end

    assign alu_ready  = w_alu_ready;
    assign mem_ready  = w_mem_ready;
    assign w_alu_xfer = alu_valid & w_alu_ready;
    assign w_mem_xfer = mem_valid & w_mem_ready;

    assign w_wr_rd   = w_alu_xfer ? alu_rd   : mem_rd;
    assign w_wr_data = w_alu_xfer ? alu_data : mem_data;
    assign w_wr_en   = (w_alu_xfer | w_mem_xfer) && (w_wr_rd != '0);
    assign w_cnt_inc = r_starve_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= StNormal;
            r_starve_cnt <= 4'd0;
        end else begin
            case (r_state)
                StNormal: begin
                    if (w_alu_xfer) begin
                        r_starve_cnt <= 4'd0;
                    end else if (alu_valid && mem_valid) begin
                        r_starve_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= STARVE_LIM) begin
                            r_state <= StForceAlu;
                        end
                    end
                end
                StForceAlu: begin
                    // Dropping alu_valid here is a protocol violation; recover to normal.
                    if (w_alu_xfer || !alu_valid) begin
                        r_state      <= StNormal;
                        r_starve_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_state      <= StNormal;
                    r_starve_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wr_en;
            if (w_wr_en) begin
                r_a3  <= w_wr_rd;
                r_wd3 <= w_wr_data;
            end
        end
    end

    // Set after clear so a newly issued load to the same register stays pending.
    always_comb begin
        w_sb_next = r_sb_busy;
        if (w_mem_xfer) begin
            w_sb_next[mem_rd] = 1'b0;
        end
        if (ld_issue && (ld_rd != '0)) begin
            w_sb_next[ld_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_sb_busy <= '0;
        end else begin
            r_sb_busy <= w_sb_next;
        end
    end

    assign WE3     = r_we3;
    assign A3      = r_a3;
    assign WD3     = r_wd3;
    assign sb_busy = r_sb_busy;

    assign w_rs1_busy = (rs1 != '0) && r_sb_busy[rs1];
    assign w_rs2_busy = (rs2 != '0) && r_sb_busy[rs2];
    assign w_rs1_fly  = (rs1 != '0) && r_we3 && (r_a3 == rs1);
    assign w_rs2_fly  = (rs2 != '0) && r_we3 && (r_a3 == rs2);

`ifdef RF_WB_BYPASS_EN
    assign hazard   = w_rs1_busy | w_rs2_busy;
    assign byp1_hit = w_rs1_fly;
    assign byp2_hit = w_rs2_fly;
    assign byp_data = r_wd3;
`else
    assign hazard = w_rs1_busy | w_rs2_busy | w_rs1_fly | w_rs2_fly;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (defaults: 32 regs, STARVE_MAX=3).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic        alu_valid, mem_valid, ld_issue;
    logic [4:0]  alu_rd, mem_rd, ld_rd, rs1, rs2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, hazard, WE3;
    logic [4:0]  A3;
    logic [31:0] WD3, sb_busy;
`ifdef RF_WB_BYPASS_EN
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp_data;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] pat;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .RST(RST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .WE3(WE3), .A3(A3), .WD3(WD3), .sb_busy(sb_busy)
`ifdef RF_WB_BYPASS_EN
        , .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; ld_issue = 1'b1;
        alu_rd = 5'd3; mem_rd = 5'd4; ld_rd = 5'd4; rs1 = 5'd0; rs2 = 5'd0;
        alu_data = 32'h1; mem_data = 32'h2;

        // Reset held two cycles with every request asserted
        tick(); tick();
        chk("rst_we3", WE3, 0);
        chk("rst_sb", sb_busy, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        RST = 1'b0;
        #1;
        chk("rel_mem_ready", mem_ready, 1);
        chk("rel_alu_ready", alu_ready, 0);
        alu_valid = 1'b0; mem_valid = 1'b0; ld_issue = 1'b0;

        // ALU alone
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_alone_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        chk("alu_we3", WE3, 1);
        chk("alu_a3", A3, 5);
        chk("alu_wd3", WD3, 32'hDEADBEEF);
`ifdef RF_WB_BYPASS_EN
        chk("alu_hazard_byp", hazard, 0);
        chk("alu_byp1_hit", byp1_hit, 1);
        chk("alu_byp_data", byp_data, 32'hDEADBEEF);
`else
        chk("alu_hazard_fly", hazard, 1);
`endif
        tick();
        chk("idle_we3", WE3, 0);
        chk("idle_a3_hold", A3, 5);
        chk("idle_hazard", hazard, 0);

        // Continuous contention: mem, mem, mem, alu repeating (bit i = ALU granted)
        pat = 8'b1000_1000;
        rs1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("starve_alu_ready[%0d]", i), alu_ready, pat[i]);
            chk($sformatf("starve_mem_ready[%0d]", i), mem_ready, !pat[i]);
            tick();
            chk($sformatf("starve_a3[%0d]", i), A3, pat[i] ? 10 : 11);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Scoreboard set by load issue, cleared by its return
        ld_issue = 1'b1; ld_rd = 5'd7;
        tick();
        ld_issue = 1'b0; rs1 = 5'd0; rs2 = 5'd7;
        #1;
        chk("sb_set7", sb_busy, 32'h0000_0080);
        chk("sb_hazard7", hazard, 1);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12345678;
        #1;
        chk("ld_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("sb_clr7", sb_busy, 0);
        chk("ld_we3", WE3, 1);
        chk("ld_a3", A3, 7);
        chk("ld_wd3", WD3, 32'h12345678);
`ifdef RF_WB_BYPASS_EN
        chk("ld_hazard_byp", hazard, 0);
        chk("ld_byp2_hit", byp2_hit, 1);
`else
        chk("ld_hazard_fly", hazard, 1);
`endif

        // Same-edge set and clear of reg 9: set wins
        ld_issue = 1'b1; ld_rd = 5'd9;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h55;
        tick();
        ld_issue = 1'b0; mem_valid = 1'b0;
        chk("sb_setwins9", sb_busy, 32'h0000_0200);
        chk("setwins_a3", A3, 9);

        // x0 sources never stall; x0 writes are accepted but dropped
        rs1 = 5'd0; rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        chk("x0_hazard", hazard, 0);
        chk("x0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("x0_we3", WE3, 0);
        rs1 = 5'd9;
        #1;
        chk("rs9_hazard", hazard, 1);
        rs1 = 5'd0;
        ld_issue = 1'b1; ld_rd = 5'd0;
        tick();
        ld_issue = 1'b0;
        chk("ld_x0_sb", sb_busy, 32'h0000_0200);

        // Reset mid-operation drops in-flight write and pending bits
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h77;
        ld_issue = 1'b1; ld_rd = 5'd13;
        tick();
        alu_valid = 1'b0; ld_issue = 1'b0;
        chk("pre_rst_we3", WE3, 1);
        chk("pre_rst_sb", sb_busy, 32'h0000_2200);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_we3", WE3, 0);
        chk("mid_rst_sb", sb_busy, 0);
        chk("mid_rst_wd3", WD3, 0);

        // Forced-ALU recovery when alu_valid drops, then counter restarts from zero
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hE;
        mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 32'hF;
        tick(); tick(); tick();
        alu_valid = 1'b0;
        #1;
        chk("force_alu_ready", alu_ready, 1);
        chk("force_mem_ready_novalid", mem_ready, 1);
        tick();
        alu_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("recov_alu_ready[%0d]", i), alu_ready, (i == 3));
            chk($sformatf("recov_mem_ready[%0d]", i), mem_ready, (i != 3));
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100us");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port (WE3/A3/WD3) in the cached RISC-V core.
- Arbitrates between ALU writeback and load-data return from the data cache. Load returns can arrive late after a miss.
- Keeps a per-register pending-load scoreboard and raises a read-after-write hazard for the decode stage.
- Sits between the execute/memory stages and the register file; all register-file writes pass through it.

Parameters:
- ADDR_W, 5, register index width (32 registers)
- DATA_W, 32, register data width
- STARVE_MAX, 3, consecutive denied ALU cycles before ALU is forced a grant (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load-return writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- ld_issue  in  1  a load leaves issue this cycle
- ld_rd  in  ADDR_W  destination of issuing load
- rs1, rs2  in  ADDR_W  decode-stage source registers
- hazard  out  1  decode must stall
- WE3  out  1  register-file write enable (registered)
- A3  out  ADDR_W  register-file write address (registered)
- WD3  out  DATA_W  register-file write data (registered)
- sb_busy  out  2**ADDR_W  pending-load bit per register

Behaviour:
- Reset (RST=1 at edge): WE3=0, A3=0, WD3=0, sb_busy=0, starve_cnt=0, state=NORMAL.
- alu_ready and mem_ready are low while RST is high.
- Handshake: a transfer occurs when valid&ready are both high at an edge. A requester holds valid, rd and data stable until accepted.
- FSM states: NORMAL, FORCE_ALU.
- NORMAL:
  - mem_ready=1.
  - alu_ready=!mem_valid.
- FORCE_ALU:
  - alu_ready=1.
  - mem_ready=!alu_valid.
- alu_ready and mem_ready are never both high while both valids are high.
- starve_cnt:
  - In NORMAL, +1 on each cycle with alu_valid&mem_valid.
  - Cleared on any ALU transfer.
  - When starve_cnt==STARVE_MAX at an edge, go to FORCE_ALU.
- FORCE_ALU to NORMAL after the ALU transfer, or when alu_valid is low (protocol violation recovery). Either path clears starve_cnt.
- Write port: a transfer at edge N sets WE3=1, A3=rd, WD3=data for cycle N+1.
  - The register file commits at edge N+1.
  - With no transfer, WE3=0 and A3/WD3 hold their previous values.
- x0 protection: a transfer with rd==0 is accepted (ready as normal), but WE3 stays 0.
- Scoreboard:
  - sb_busy[ld_rd] is set at an edge with ld_issue=1 and ld_rd!=0.
  - sb_busy[mem_rd] is cleared at an edge with a mem transfer.
  - Same register set and cleared at the same edge: set wins (newer load).
- hazard is combinational. It is 1 if, for either rs in {rs1, rs2} with rs!=0:
  - sb_busy[rs]=1, or
  - WE3=1 and A3==rs (write in flight; the register file still returns old data this cycle).
- rs==0 never causes a hazard.
- Reset mid-operation: in-flight WE3 is dropped at the reset edge, and all pending bits are lost. The pipeline is flushed by the same reset.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- When defined, adds outputs byp1_hit (1), byp2_hit (1) and byp_data (DATA_W):
  - byp1_hit = WE3 & A3==rs1 & rs1!=0.
  - byp2_hit is the same for rs2.
  - byp_data = WD3.
  - The in-flight-write term is removed from hazard; only sb_busy causes a stall.
- When undefined, these ports do not exist and hazard includes the in-flight term.

Test Plan:
- Reset with RST=1 for 2 cycles, all valids=1 → WE3=0, sb_busy=0, alu_ready=mem_ready=0. After release, mem_ready=1 first.
- alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF alone → alu_ready=1. Next cycle WE3=1, A3=5, WD3=0xDEADBEEF. hazard=1 for rs1=5 in that cycle; with RF_WB_BYPASS_EN, hazard=0 and byp1_hit=1.
- Both valid continuously, STARVE_MAX=3 → mem granted 3 cycles, ALU granted on the 4th, mem granted the cycle after. Repeat pattern matches exactly.
- ld_issue with ld_rd=7 → sb_busy[7]=1 and hazard=1 for rs2=7. mem transfer with mem_rd=7, data 0x12345678 → bit clears. Next cycle WE3=1, A3=7, WD3=0x12345678.
- ld_issue(rd=9) and mem transfer(rd=9) at the same edge → sb_busy[9] remains 1.
- alu transfer with alu_rd=0, data 0xFFFFFFFF → alu_ready=1, WE3 stays 0. Also rs1=rs2=0 with any sb state → hazard=0.
